// File: rtl/nrzi_serial_encoder.sv
// nrzi_serial_encoder: accepts parallel words over valid/ready, serialises them
// LSB-first at the ce_i bit-rate strobe, optionally inserts a stuffed 0 after a
// run of 1s, and NRZI-encodes the raw stream onto a single line.
module nrzi_serial_encoder #(
  parameter int DATA_WIDTH    = 8,
  parameter int STUFF_LEN     = 0,
  parameter bit TOGGLE_ON_ONE = 1'b1,
  parameter bit IDLE_LEVEL    = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ce_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  output_en_i,
  output logic                  data_o,
  output logic                  oe_o,
  output logic                  busy_o,
  output logic                  stuff_o,
  output logic                  underrun_o
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int OW = (STUFF_LEN > 0) ? $clog2(STUFF_LEN + 1) : 1;
  localparam bit STUFF_EN = (STUFF_LEN > 0);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [OW-1:0] STUFF_LIM = OW'(STUFF_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STUFF = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
  logic [OW-1:0]         ones_cnt_reg, ones_cnt_next;
  // shift register still holds data bits that have not been put on the line
  logic                  word_valid_reg, word_valid_next;
  // the most recent ce_i strobe put a data or stuff bit on the line
  logic                  emitted_reg, emitted_next;
  logic                  line_reg, line_next;
  logic                  stuff_reg, stuff_next;
  logic                  underrun_reg, underrun_next;
  logic                  oe_reg;

  logic raw_bit;
  logic last_bit;
  logic accept;
  logic stuff_hit;

  assign raw_bit  = shift_reg[0];
  assign last_bit = (state_reg == SHIFT) && (bit_cnt_reg == LAST_BIT);
  // Ready when nothing is waiting, or when the final bit leaves on this strobe,
  // so a held valid_i streams words without a gap.
  assign ready_o  = !word_valid_reg || (ce_i && last_bit);
  assign accept   = valid_i && ready_o;

  assign data_o     = oe_reg ? line_reg : IDLE_LEVEL;
  assign oe_o       = oe_reg;
  assign busy_o     = (state_reg != IDLE);
  assign stuff_o    = stuff_reg;
  assign underrun_o = underrun_reg;

  // Next-state, serialiser, stuffing and NRZI line computation.
  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    bit_cnt_next    = bit_cnt_reg;
    ones_cnt_next   = ones_cnt_reg;
    word_valid_next = word_valid_reg;
    emitted_next    = emitted_reg;
    line_next       = line_reg;
    stuff_next      = 1'b0;
    underrun_next   = 1'b0;
    stuff_hit       = 1'b0;

    if (ce_i) begin
      case (state_reg)
        SHIFT: begin
          emitted_next = 1'b1;
          line_next    = line_reg ^ (TOGGLE_ON_ONE ? raw_bit : ~raw_bit);
          shift_next   = shift_reg >> 1;
          bit_cnt_next = bit_cnt_reg + BW'(1);
          if (raw_bit && STUFF_EN) begin
            ones_cnt_next = ones_cnt_reg + OW'(1);
            stuff_hit     = ((ones_cnt_reg + OW'(1)) == STUFF_LIM);
          end else begin
            ones_cnt_next = '0;
          end
          if (last_bit) begin
            word_valid_next = 1'b0;
          end
          if (stuff_hit) begin
            state_next = STUFF;
          end else if (last_bit) begin
            state_next = IDLE;
          end
        end
        STUFF: begin
          emitted_next  = 1'b1;
          line_next     = line_reg ^ ~TOGGLE_ON_ONE;
          stuff_next    = 1'b1;
          ones_cnt_next = '0;
          state_next    = word_valid_reg ? SHIFT : IDLE;
        end
        default: begin
          // strobe with nothing to send: the line holds; flag a broken stream
          emitted_next = 1'b0;
          if (emitted_reg) begin
            underrun_next = 1'b1;
            ones_cnt_next = '0;
          end
        end
      endcase
    end

    // A pending stuff bit always goes out before the newly loaded word.
    if (accept) begin
      shift_next      = data_i;
      bit_cnt_next    = '0;
      word_valid_next = 1'b1;
      if ((state_reg == IDLE) || (ce_i && !stuff_hit)) begin
        state_next = SHIFT;
      end
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      ones_cnt_reg   <= '0;
      word_valid_reg <= 1'b0;
      emitted_reg    <= 1'b0;
      line_reg       <= IDLE_LEVEL;
      stuff_reg      <= 1'b0;
      underrun_reg   <= 1'b0;
      oe_reg         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      ones_cnt_reg   <= ones_cnt_next;
      word_valid_reg <= word_valid_next;
      emitted_reg    <= emitted_next;
      line_reg       <= line_next;
      stuff_reg      <= stuff_next;
      underrun_reg   <= underrun_next;
      oe_reg         <= output_en_i;
    end
  end

endmodule

// File: tb/tb_nrzi_serial_encoder.sv
// Bench for nrzi_serial_encoder: three instances (ADAT-style, USB-style with
// idle 0, USB-style with idle 1) driven from one directed sequence. Expected
// line levels are produced by a stream model and queued per instance at
// accept time, then popped whenever the instance emits a bit.
module tb_nrzi_serial_encoder;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic       oe_en;
  logic [7:0] data  [3];
  logic       valid [3];
  logic       ready [3];
  logic       dout  [3];
  logic       oe    [3];
  logic       busy  [3];
  logic       stuff [3];
  logic       under [3];

  int checks = 0;
  int errors = 0;
  int ce_div = 1;
  int ce_cnt = 0;

  // scoreboard entries: {stuff flag, line level after the bit}
  logic [1:0] sb [3][$];
  logic       m_line [3];
  logic       m_cur  [3];
  logic       m_emit [3];
  int         m_ones [3];
  int         busy_low [3];
  int         rdy_busy [3];

  nrzi_serial_encoder #(.DATA_WIDTH(8), .STUFF_LEN(0), .TOGGLE_ON_ONE(1'b1), .IDLE_LEVEL(1'b0)) dut_adat (
    .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .data_i(data[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .output_en_i(oe_en), .data_o(dout[0]), .oe_o(oe[0]),
    .busy_o(busy[0]), .stuff_o(stuff[0]), .underrun_o(under[0]));

  nrzi_serial_encoder #(.DATA_WIDTH(8), .STUFF_LEN(6), .TOGGLE_ON_ONE(1'b0), .IDLE_LEVEL(1'b0)) dut_usb0 (
    .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .data_i(data[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .output_en_i(oe_en), .data_o(dout[1]), .oe_o(oe[1]),
    .busy_o(busy[1]), .stuff_o(stuff[1]), .underrun_o(under[1]));

  nrzi_serial_encoder #(.DATA_WIDTH(8), .STUFF_LEN(6), .TOGGLE_ON_ONE(1'b0), .IDLE_LEVEL(1'b1)) dut_usb1 (
    .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .data_i(data[2]), .valid_i(valid[2]),
    .ready_o(ready[2]), .output_en_i(oe_en), .data_o(dout[2]), .oe_o(oe[2]),
    .busy_o(busy[2]), .stuff_o(stuff[2]), .underrun_o(under[2]));

  function automatic logic tog(input int d);
    return (d == 0);
  endfunction

  function automatic int slen(input int d);
    return (d == 0) ? 0 : 6;
  endfunction

  function automatic logic idle_lvl(input int d);
    return (d == 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_line[d] = idle_lvl(d);
      m_cur[d]  = idle_lvl(d);
      m_emit[d] = 1'b0;
      m_ones[d] = 0;
      sb[d].delete();
    end
  endtask

  task automatic emit_bit(input int d, input logic b, input logic stf);
    if (tog(d) ? b : !b) m_line[d] = !m_line[d];
    sb[d].push_back({stf, m_line[d]});
  endtask

  // raw stream model: LSB first, a 0 inserted after slen consecutive 1s
  task automatic push_word(input int d, input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      emit_bit(d, w[i], 1'b0);
      if (w[i]) begin
        m_ones[d]++;
        if (slen(d) > 0 && m_ones[d] == slen(d)) begin
          emit_bit(d, 1'b0, 1'b1);
          m_ones[d] = 0;
        end
      end else begin
        m_ones[d] = 0;
      end
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input int d, input logic [7:0] w, output int waited);
    data[d]  = w;
    valid[d] = 1'b1;
    waited   = 0;
    #2;
    while (!ready[d] && waited < 300) begin
      @(negedge clk);
      #2;
      waited++;
    end
    if (!ready[d]) begin
      chk($sformatf("accept_wait_dut%0d", d), 32'(ready[d]), 32'd1);
      valid[d] = 1'b0;
      return;
    end
    push_word(d, w);
    @(negedge clk);
    valid[d] = 1'b0;
  endtask

  task automatic wait_size(input int d, input int n);
    int k = 0;
    while (sb[d].size() > n && k < 400) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic drain(input int d);
    int k = 0;
    while (sb[d].size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("drain_dut%0d", d), 32'(sb[d].size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // bit-rate strobe: every clock, or every ce_div-th clock
  initial begin
    ce = 1'b0;
    forever begin
      @(negedge clk);
      ce_cnt++;
      ce = (ce_div == 1) || (ce_cnt % ce_div == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Monitor: captures pre-edge inputs mid-cycle, checks outputs 1 ns after the edge.
  always begin : monitor
    logic [1:0] e;
    logic       exp_line, exp_stuff, exp_under;
    logic       pc, po, pr;
    logic       pend [3];
    logic       pb   [3];
    @(negedge clk);
    #2;
    pc = ce;
    po = oe_en;
    pr = rst_n;
    for (int d = 0; d < 3; d++) begin
      pb[d]   = busy[d];
      pend[d] = pr && pc && busy[d];
      if (pr && !busy[d]) busy_low[d]++;
      if (pr && busy[d] && ready[d]) rdy_busy[d]++;
    end
    @(posedge clk);
    #1;
    if (pr && rst_n) begin
      for (int d = 0; d < 3; d++) begin
        exp_stuff = 1'b0;
        exp_under = 1'b0;
        if (pend[d]) begin
          if (sb[d].size() == 0) begin
            chk($sformatf("unexpected_bit_dut%0d", d), 32'(sb[d].size()), 32'd1);
          end else begin
            e = sb[d].pop_front();
            m_cur[d]  = e[0];
            exp_stuff = e[1];
          end
        end
        if (pc) begin
          exp_under = !pb[d] && m_emit[d];
          if (exp_under) m_ones[d] = 0;
          m_emit[d] = pb[d];
        end
        exp_line = po ? m_cur[d] : idle_lvl(d);
        chk($sformatf("data_o_dut%0d", d), 32'(dout[d]), 32'(exp_line));
        chk($sformatf("stuff_o_dut%0d", d), 32'(stuff[d]), 32'(exp_stuff));
        chk($sformatf("underrun_o_dut%0d", d), 32'(under[d]), 32'(exp_under));
        chk($sformatf("oe_o_dut%0d", d), 32'(oe[d]), 32'(po));
      end
    end
  end

  initial begin : stimulus
    int wt;
    int bl0, rb0;
    rst_n = 1'b0;
    oe_en = 1'b0;
    for (int d = 0; d < 3; d++) begin
      data[d]  = 8'h00;
      valid[d] = 1'b0;
      busy_low[d] = 0;
      rdy_busy[d] = 0;
    end
    model_reset();

    // reset state
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_data_o_dut%0d", d), 32'(dout[d]), 32'(idle_lvl(d)));
      chk($sformatf("rst_oe_o_dut%0d", d), 32'(oe[d]), 32'd0);
      chk($sformatf("rst_busy_o_dut%0d", d), 32'(busy[d]), 32'd0);
      chk($sformatf("rst_stuff_o_dut%0d", d), 32'(stuff[d]), 32'd0);
      chk($sformatf("rst_underrun_o_dut%0d", d), 32'(under[d]), 32'd0);
      chk($sformatf("rst_ready_o_dut%0d", d), 32'(ready[d]), 32'd1);
    end
    oe_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("step: reset released");

    // ADAT 0xA5: line 1,1,0,0,0,1,1,0 then one underrun pulse, line holds 0
    @(negedge clk);
    send(0, 8'hA5, wt);
    drain(0);
    @(posedge clk);
    #1;
    chk("a5_underrun_pulse", 32'(under[0]), 32'd1);
    chk("a5_line_hold", 32'(dout[0]), 32'd0);
    chk("a5_busy_after", 32'(busy[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("a5_underrun_single", 32'(under[0]), 32'd0);
    $display("step: adat 0xA5 done");

    // USB 0xFF then 0x00 back-to-back: 17 bit-times with a stuff bit at 7
    do_reset();
    send(1, 8'hFF, wt);
    send(1, 8'h00, wt);
    chk("ff00_second_accept_wait", 32'(wt), 32'd8);
    drain(1);
    $display("step: usb 0xFF,0x00 done");

    // stuffing across the word boundary: 0xE0 then 0x07
    do_reset();
    send(1, 8'hE0, wt);
    send(1, 8'h07, wt);
    chk("e007_second_accept_wait", 32'(wt), 32'd7);
    drain(1);
    $display("step: usb 0xE0,0x07 done");

    // ce every 4th clock, three words streamed
    do_reset();
    ce_div = 4;
    send(0, 8'h3C, wt);
    bl0 = busy_low[0];
    rb0 = rdy_busy[0];
    send(0, 8'h96, wt);
    send(0, 8'h0F, wt);
    drain(0);
    chk("stream_busy_gaps", 32'(busy_low[0] - bl0), 32'd0);
    chk("stream_ready_pulses", 32'(rdy_busy[0] - rb0), 32'd3);
    ce_div = 1;
    $display("step: strobed stream done");

    // output disable mid-word with idle level 1
    do_reset();
    send(2, 8'h5A, wt);
    wait_size(2, 7);
    oe_en = 1'b0;
    @(posedge clk);
    #1;
    chk("oe_off_data_o", 32'(dout[2]), 32'd1);
    chk("oe_off_oe_o", 32'(oe[2]), 32'd0);
    repeat (2) @(negedge clk);
    oe_en = 1'b1;
    @(posedge clk);
    #1;
    chk("oe_on_oe_o", 32'(oe[2]), 32'd1);
    @(negedge clk);
    drain(2);
    $display("step: output enable done");

    // asynchronous reset mid-word, then a fresh word from the reset line state
    do_reset();
    send(0, 8'h3C, wt);
    wait_size(0, 3);
    chk("pre_reset_line", 32'(dout[0]), 32'd1);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_data_o", 32'(dout[0]), 32'd0);
    chk("async_rst_busy_o", 32'(busy[0]), 32'd0);
    chk("async_rst_stuff_o", 32'(stuff[0]), 32'd0);
    chk("async_rst_underrun_o", 32'(under[0]), 32'd0);
    chk("async_rst_oe_o", 32'(oe[0]), 32'd0);
    chk("async_rst_usb1_data_o", 32'(dout[2]), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("post_rst_ready_o", 32'(ready[0]), 32'd1);
    chk("post_rst_busy_o", 32'(busy[0]), 32'd0);
    repeat (3) @(negedge clk);
    send(0, 8'h01, wt);
    drain(0);
    repeat (3) @(negedge clk);
    $display("step: async reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
